// File: rtl/code_mem_sequencer.sv
// code_mem_sequencer: run/halt/step controller and code-memory arbiter for the
// 8-bit stack CPU. It shares one single-port code memory between CPU fetch and
// a byte-stream program loader, gates the CPU with a clock enable, and issues a
// fixed-length CPU reset after every program load.
// Optional feature macro: CYCLE_COUNT_EN (enabled-cycle counter on run_cycles).
module code_mem_sequencer #(
   parameter int ADDR_W     = 12,
   parameter int DEPTH      = 512,
   parameter int LOAD_BASE  = 0,
   parameter int RST_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd,
   output logic              cmd_ready,
   output logic              cmd_err,
   input  logic              ld_valid,
   input  logic              ld_last,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              ld_overflow,
   input  logic [ADDR_W-1:0] cpu_fetch_addr,
   input  logic              cpu_halt,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic [2:0]        state_o,
   output logic [15:0]       run_cycles
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [1:0] CMD_RUN  = 2'd0;
   localparam logic [1:0] CMD_HALT = 2'd1;
   localparam logic [1:0] CMD_STEP = 2'd2;
   localparam logic [1:0] CMD_LOAD = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(LOAD_BASE);

   typedef enum logic [2:0] {
      S_HALT = 3'd0,
      S_RUN  = 3'd1,
      S_STEP = 3'd2,
      S_LOAD = 3'd3,
      S_RSTP = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ld_addr, ld_addr_nxt;
   logic              ovf, ovf_nxt;
   logic [CNT_W-1:0]  rst_cnt, rst_cnt_nxt;
   logic              cmd_acc;
   logic              byte_acc;

   assign cmd_acc     = cmd_valid && cmd_ready;
   assign byte_acc    = ld_valid && ld_ready;
   assign mem_we      = byte_acc;
   assign mem_wdata   = ld_data;
   assign ld_overflow = ovf;
   assign state_o     = state;

   // State, load address, overflow flag and reset-pulse counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_HALT;
         ld_addr <= ADDR_BASE;
         ovf     <= 1'b0;
         rst_cnt <= '0;
      end else begin
         state   <= state_nxt;
         ld_addr <= ld_addr_nxt;
         ovf     <= ovf_nxt;
         rst_cnt <= rst_cnt_nxt;
      end
   end

   // Next-state logic and per-state outputs; memory follows CPU fetch unless loading
   always_comb begin
      state_nxt   = state;
      ld_addr_nxt = ld_addr;
      ovf_nxt     = ovf;
      rst_cnt_nxt = rst_cnt;
      cmd_ready   = 1'b0;
      cmd_err     = 1'b0;
      ld_ready    = 1'b0;
      cpu_en      = 1'b0;
      cpu_rst     = 1'b0;
      mem_addr    = cpu_fetch_addr;
      case (state)
         S_HALT: begin
            cmd_ready = 1'b1;
            if (cmd_acc) begin
               case (cmd)
                  CMD_RUN:  state_nxt = S_RUN;
                  CMD_STEP: state_nxt = S_STEP;
                  CMD_LOAD: begin
                     state_nxt   = S_LOAD;
                     ld_addr_nxt = ADDR_BASE;
                     ovf_nxt     = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cmd_ready = 1'b1;
            cpu_en    = 1'b1;
            // a CPU halt and a host HALT in the same cycle collapse into one transition
            if (cpu_halt || (cmd_acc && cmd == CMD_HALT))
               state_nxt = S_HALT;
            if (cmd_acc && cmd != CMD_HALT)
               cmd_err = 1'b1;
         end
         S_STEP: begin
            // cpu_halt is irrelevant here: we return to HALT regardless
            cpu_en    = 1'b1;
            state_nxt = S_HALT;
         end
         S_LOAD: begin
            ld_ready = 1'b1;
            mem_addr = ld_addr;
            if (byte_acc) begin
               if (ld_addr == ADDR_LAST) begin
                  ld_addr_nxt = '0;
                  ovf_nxt     = 1'b1;
               end else begin
                  ld_addr_nxt = ld_addr + ADDR_W'(1);
               end
               if (ld_last) begin
                  state_nxt   = S_RSTP;
                  rst_cnt_nxt = CNT_W'(RST_CYCLES - 1);
               end
            end
         end
         S_RSTP: begin
            cpu_en  = 1'b1;
            cpu_rst = 1'b1;
            if (rst_cnt == '0)
               state_nxt = S_HALT;
            else
               rst_cnt_nxt = rst_cnt - CNT_W'(1);
         end
         default: state_nxt = S_HALT;
      endcase
   end

`ifdef CYCLE_COUNT_EN
   logic [15:0] cyc_cnt;

   // Saturating count of cycles the CPU actually executes; restarts with each load
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cyc_cnt <= '0;
      else if (state != S_RSTP && state_nxt == S_RSTP)
         cyc_cnt <= '0;
      else if (cpu_en && !cpu_rst && cyc_cnt != 16'hFFFF)
         cyc_cnt <= cyc_cnt + 16'd1;
   end

   assign run_cycles = cyc_cnt;
`else
   assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_code_mem_sequencer.sv
// Self-checking bench for code_mem_sequencer. Two instances share all inputs:
// one loads at base 0, the other at base 510 to exercise address wrap.
module tb_code_mem_sequencer;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 512;
   localparam int BASE_B = 510;
   localparam int ST_HALT = 0, ST_RUN = 1, ST_STEP = 2, ST_LOAD = 3, ST_RSTP = 4;
   localparam logic [1:0] C_RUN = 2'd0, C_HALT = 2'd1, C_STEP = 2'd2, C_LOAD = 2'd3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd = 2'd0;
   logic              ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0]        ld_data = 8'd0;
   logic [ADDR_W-1:0] cpu_fetch_addr = '0;
   logic              cpu_halt = 1'b0;

   logic              cmd_ready, cmd_err, ld_ready, ld_overflow, cpu_en, cpu_rst, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [2:0]        state_o;
   logic [15:0]       run_cycles;

   logic              cmd_ready_b, cmd_err_b, ld_ready_b, ld_overflow_b, cpu_en_b, cpu_rst_b, mem_we_b;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [7:0]        mem_wdata_b;
   logic [2:0]        state_o_b;
   logic [15:0]       run_cycles_b;

   code_mem_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_BASE(0), .RST_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready), .cmd_err(cmd_err), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_data(ld_data), .ld_ready(ld_ready), .ld_overflow(ld_overflow),
      .cpu_fetch_addr(cpu_fetch_addr), .cpu_halt(cpu_halt), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .state_o(state_o),
      .run_cycles(run_cycles));

   code_mem_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_BASE(BASE_B), .RST_CYCLES(4)) dut_b (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready_b), .cmd_err(cmd_err_b), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_data(ld_data), .ld_ready(ld_ready_b), .ld_overflow(ld_overflow_b),
      .cpu_fetch_addr(cpu_fetch_addr), .cpu_halt(cpu_halt), .cpu_en(cpu_en_b), .cpu_rst(cpu_rst_b),
      .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .state_o(state_o_b),
      .run_cycles(run_cycles_b));

   // Code memories written by the sequencers
   logic [7:0] mem_a [0:DEPTH-1];
   logic [7:0] mem_b [0:DEPTH-1];
   always @(posedge clock) begin
      if (mem_we)   mem_a[mem_addr[8:0]]   <= mem_wdata;
      if (mem_we_b) mem_b[mem_addr_b[8:0]] <= mem_wdata_b;
   end

   int tests  = 0;
   int failed = 0;
   int exp_run = 0;         // executed (enabled, non-reset) CPU cycles since last load
   logic [7:0] pl [$];      // current program payload

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rc();
`ifdef CYCLE_COUNT_EN
      return (exp_run > 65535) ? 32'd65535 : 32'(exp_run);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue a one-cycle command; caller knows the state it is issued in
   task automatic do_cmd(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd = c;
      #1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Stream pl with random stalls; expected write addresses are base+i mod DEPTH
   task automatic load_stream();
      for (int i = 0; i < pl.size(); i++) begin
         int st = $urandom_range(0, 2);
         repeat (st) begin
            ld_valid = 1'b0;
            #1;
            chk("stall_we", mem_we, 0);
            chk("stall_state", state_o, ST_LOAD);
            tick();
         end
         ld_valid = 1'b1;
         ld_data  = pl[i];
         ld_last  = (i == pl.size() - 1);
         #1;
         chk("ld_we", mem_we, 1);
         chk("ld_addr_a", mem_addr, i % DEPTH);
         chk("ld_addr_b", mem_addr_b, (BASE_B + i) % DEPTH);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // Expect the 4-cycle CPU reset pulse, then HALT; also check memory contents
   task automatic check_rstp_and_mem();
      for (int k = 0; k < 4; k++) begin
         chk("rstp_state", state_o, ST_RSTP);
         chk("rstp_rst", cpu_rst, 1);
         chk("rstp_en", cpu_en, 1);
         chk("rstp_cmd_ready", cmd_ready, 0);
         tick();
      end
      exp_run = 0;
      chk("post_rstp_state", state_o, ST_HALT);
      chk("post_rstp_en", cpu_en, 0);
      chk("post_rstp_rst", cpu_rst, 0);
      chk("post_rstp_run_cycles", run_cycles, exp_rc());
      for (int i = 0; i < pl.size(); i++) begin
         chk("mem_a", mem_a[i % DEPTH], pl[i]);
         chk("mem_b", mem_b[(BASE_B + i) % DEPTH], pl[i]);
      end
      chk("ovf_a", ld_overflow, (pl.size() >= DEPTH) ? 1 : 0);
      chk("ovf_b", ld_overflow_b, (BASE_B + pl.size() >= DEPTH) ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, en_seen;

      // Reset values
      cpu_fetch_addr = ADDR_W'($urandom);
      #1;
      chk("rst_state", state_o, ST_HALT);
      chk("rst_en", cpu_en, 0);
      chk("rst_cpu_rst", cpu_rst, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_ovf", ld_overflow, 0);
      chk("rst_run_cycles", run_cycles, 0);
      chk("rst_mem_addr", mem_addr, cpu_fetch_addr);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Load the 5-byte program
      do_cmd(C_LOAD);
      #1;
      chk("load_state", state_o, ST_LOAD);
      chk("load_ld_ready", ld_ready, 1);
      chk("load_cmd_ready", cmd_ready, 0);
      chk("load_en", cpu_en, 0);
      pl = '{8'h80, 8'h81, 8'h20, 8'h41, 8'h44};
      load_stream();
      check_rstp_and_mem();

      // RUN until the CPU halts after 7 enabled cycles
      do_cmd(C_RUN);
      n = 7;
      for (int c = 1; c <= n; c++) begin
         cpu_fetch_addr = ADDR_W'($urandom);
         cpu_halt = (c == n);
         #1;
         chk("run_state", state_o, ST_RUN);
         chk("run_en", cpu_en, 1);
         chk("run_mem_addr", mem_addr, cpu_fetch_addr);
         exp_run++;
         tick();
      end
      cpu_halt = 1'b0;
      chk("run_halt_state", state_o, ST_HALT);
      chk("run_halt_en", cpu_en, 0);
      chk("run_cycles_7", run_cycles, exp_rc());

      // Three single steps; cpu_halt during the second is ignored
      for (int s = 0; s < 3; s++) begin
         do_cmd(C_STEP);
         en_seen = 0;
         for (int c = 0; c < 3; c++) begin
            cpu_fetch_addr = ADDR_W'($urandom);
            cpu_halt = (s == 1 && c == 0);
            #1;
            chk("step_mem_addr", mem_addr, cpu_fetch_addr);
            chk("step_state", state_o, (c == 0) ? ST_STEP : ST_HALT);
            if (cpu_en) en_seen++;
            if (c == 0) exp_run++;
            tick();
            cpu_halt = 1'b0;
         end
         chk("step_pulses", en_seen, 1);
      end
      chk("step_run_cycles", run_cycles, exp_rc());

      // Illegal commands in RUN pulse cmd_err; HALT with cpu_halt is one transition
      do_cmd(C_RUN);
      for (int e = 0; e < 3; e++) begin
         cmd_valid = 1'b1;
         cmd = (e == 0) ? C_LOAD : (e == 1) ? C_STEP : C_RUN;
         #1;
         chk("err_pulse", cmd_err, 1);
         exp_run++;
         tick();
         cmd_valid = 1'b0;
         #1;
         chk("err_clear", cmd_err, 0);
         chk("err_state", state_o, ST_RUN);
         exp_run++;
         tick();
      end
      cmd_valid = 1'b1;
      cmd = C_HALT;
      cpu_halt = 1'b1;
      #1;
      chk("halt_both_err", cmd_err, 0);
      exp_run++;
      tick();
      cmd_valid = 1'b0;
      cpu_halt = 1'b0;
      chk("halt_both_state", state_o, ST_HALT);
      tick();
      chk("halt_both_stay", state_o, ST_HALT);
      chk("err_run_cycles", run_cycles, exp_rc());
      do_cmd(C_HALT);
      chk("halt_noop", state_o, ST_HALT);

      // 4-byte random load: instance B wraps 510,511,0,1; LOAD clears old overflow
      do_cmd(C_LOAD);
      #1;
      chk("reload_ovf_clear", ld_overflow_b, 0);
      chk("reload_addr_a", mem_addr, 0);
      chk("reload_addr_b", mem_addr_b, BASE_B);
      pl = {};
      for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
      load_stream();
      check_rstp_and_mem();

      // Reset in the middle of a load
      do_cmd(C_LOAD);
      pl = {};
      for (int i = 0; i < 2; i++) pl.push_back(8'($urandom));
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data = pl[i];
         tick();
      end
      ld_data = 8'($urandom);
      #1;
      chk("mid_ovf_b", ld_overflow_b, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_state", state_o, ST_HALT);
      chk("mid_rst_ld_ready", ld_ready, 0);
      chk("mid_rst_ovf_b", ld_overflow_b, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_run_cycles", run_cycles, 0);
      ld_valid = 1'b0;
      ld_data = 8'd0;
      exp_run = 0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      chk("mid_kept_byte", mem_a[1], pl[1]);
      do_cmd(C_LOAD);
      #1;
      chk("mid_base_a", mem_addr, 0);
      chk("mid_base_b", mem_addr_b, BASE_B);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
